regfile_seq_ctrl: RTL and testbench

- Operand-fetch/writeback sequencer for the multi-cycle datapath: the initiator side of the register file port.
- Accepts one instruction's register fields at a time and drives the register file's two read addresses.
- Captures the register file's one-cycle-registered read data and hands the operand pair to the execute stage over a valid/ready handshake.
- Accepts the execute result and drives the register file write port; this is the only writer of the register file.

---
 rtl/regfile_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_seq_ctrl
//
// Operand-fetch / writeback sequencer. It is the initiator side of the register
// file port. It accepts one instruction's register fields, drives the two read
// addresses, and captures the register file's one-cycle-registered read data.
// It then hands the operand pair to the execute stage over a valid/ready
// handshake, accepts the execute result, and drives the register file write
// port. This block is the only writer of the register file.
//
// Optional feature:
//   REGFILE_R0_ZERO_EN  - register 0 reads as zero. A writeback to rd=0
//                         completes its handshake, but no write is issued.
//
// Ports:
//   Clk_i, Rst_n_i                  clock (rising edge), async active-low reset
//   ReqValid_i/ReqReady_o           instruction request handshake
//   ReqRs1_i/ReqRs2_i/ReqRd_i       source/destination register addresses
//   ReqWb_i                         instruction writes a result
//   Rs1Addr_o/Rs2Addr_o             register file read addresses (latched)
//   Rs1Data_i/Rs2Data_i             read data, valid one cycle after address
//   RegWEn_o/RdAddr_o/RdData_o      register file write port
//   OpValid_o/OpReady_i/Op1_o/Op2_o operand handshake to execute stage
//   WbValid_i/WbReady_o/WbData_i    result handshake from execute stage
//   RetCnt_o                        retired-instruction count (wraps)
//   Busy_o                          sequencer not idle
// -----------------------------------------------------------------------------
module regfile_seq_ctrl #(
    parameter int REGAW = 4,
    parameter int REGDW = 16,
    parameter int CNTW  = 16
) (
    input  logic             Clk_i,
    input  logic             Rst_n_i,
    input  logic             ReqValid_i,
    output logic             ReqReady_o,
    input  logic [REGAW-1:0] ReqRs1_i,
    input  logic [REGAW-1:0] ReqRs2_i,
    input  logic [REGAW-1:0] ReqRd_i,
    input  logic             ReqWb_i,
    output logic [REGAW-1:0] Rs1Addr_o,
    output logic [REGAW-1:0] Rs2Addr_o,
    input  logic [REGDW-1:0] Rs1Data_i,
    input  logic [REGDW-1:0] Rs2Data_i,
    output logic             RegWEn_o,
    output logic [REGAW-1:0] RdAddr_o,
    output logic [REGDW-1:0] RdData_o,
    output logic             OpValid_o,
    input  logic             OpReady_i,
    output logic [REGDW-1:0] Op1_o,
    output logic [REGDW-1:0] Op2_o,
    input  logic             WbValid_i,
    output logic             WbReady_o,
    input  logic [REGDW-1:0] WbData_i,
    output logic [CNTW-1:0]  RetCnt_o,
    output logic             Busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_CAPT   = 3'd2,
        S_OPND   = 3'd3,
        S_WBWAIT = 3'd4,
        S_WRITE  = 3'd5
    } state_e;

    state_e            state_q, state_d;

    logic [REGAW-1:0]  rs1_q, rs1_d;
    logic [REGAW-1:0]  rs2_q, rs2_d;
    logic [REGAW-1:0]  rd_q,  rd_d;
    logic              wb_q,  wb_d;
    logic [REGDW-1:0]  op1_q, op1_d;
    logic [REGDW-1:0]  op2_q, op2_d;
    logic [REGDW-1:0]  wdata_q, wdata_d;
    logic [CNTW-1:0]   ret_cnt_q, ret_cnt_d;

    // Decoded per-state strobes from the output process.
    logic              req_ready;
    logic              op_valid;
    logic              wb_ready;
    logic              reg_wen;
    logic              retire;

    // A result bound for rd=0 is dropped when register 0 is hardwired to zero.
    logic              skip_write;
`ifdef REGFILE_R0_ZERO_EN
    assign skip_write = (rd_q == '0);
`else
    assign skip_write = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (ReqValid_i) state_d = S_FETCH;
            S_FETCH:  state_d = S_CAPT;
            S_CAPT:   state_d = S_OPND;
            S_OPND:   if (OpReady_i) state_d = wb_q ? S_WBWAIT : S_IDLE;
            S_WBWAIT: if (WbValid_i) state_d = skip_write ? S_IDLE : S_WRITE;
            S_WRITE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output decode
    // ---------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        op_valid  = 1'b0;
        wb_ready  = 1'b0;
        reg_wen   = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            S_IDLE:   req_ready = 1'b1;
            S_OPND: begin
                op_valid = 1'b1;
                retire   = OpReady_i && !wb_q;
            end
            S_WBWAIT: begin
                wb_ready = 1'b1;
                retire   = WbValid_i && skip_write;
            end
            S_WRITE: begin
                reg_wen = 1'b1;
                retire  = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------------
    always_comb begin
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        wb_d      = wb_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        wdata_d   = wdata_q;
        ret_cnt_d = ret_cnt_q;

        // Fields are latched only on accept. The read addresses therefore
        // hold from FETCH until the next accept instead of following the
        // request bus.
        if (state_q == S_IDLE && ReqValid_i) begin
            rs1_d = ReqRs1_i;
            rs2_d = ReqRs2_i;
            rd_d  = ReqRd_i;
            wb_d  = ReqWb_i;
        end

        // The register file registered the FETCH addresses, so its data is
        // valid during CAPT.
        if (state_q == S_CAPT) begin
`ifdef REGFILE_R0_ZERO_EN
            op1_d = (rs1_q == '0) ? '0 : Rs1Data_i;
            op2_d = (rs2_q == '0) ? '0 : Rs2Data_i;
`else
            op1_d = Rs1Data_i;
            op2_d = Rs2Data_i;
`endif
        end

        if (state_q == S_WBWAIT && WbValid_i) begin
            wdata_d = WbData_i;
        end

        if (retire) begin
            ret_cnt_d = ret_cnt_q + CNTW'(1);
        end
    end

    // NOTE: all datapath registers take the async reset. A reset in the
    // middle of an operation must leave no stale operand, address or count
    // visible on the outputs.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_q      <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            wdata_q   <= '0;
            ret_cnt_q <= '0;
        end else begin
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wb_q      <= wb_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            wdata_q   <= wdata_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // The FSM already sits in IDLE during reset. Gating with Rst_n_i keeps
    // requests from being advertised before reset is released.
    assign ReqReady_o = req_ready && Rst_n_i;
    assign OpValid_o  = op_valid;
    assign WbReady_o  = wb_ready;
    assign RegWEn_o   = reg_wen;
    assign Busy_o     = (state_q != S_IDLE);
    assign Rs1Addr_o  = rs1_q;
    assign Rs2Addr_o  = rs2_q;
    assign RdAddr_o   = rd_q;
    assign RdData_o   = wdata_q;
    assign Op1_o      = op1_q;
    assign Op2_o      = op2_q;
    assign RetCnt_o   = ret_cnt_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_regfile_seq_ctrl
//
// Directed and randomized stimulus for regfile_seq_ctrl. A register file model
// is attached to the read and write ports. Expected operands, write-port values
// and retire counts come from a transaction-level reference, which is an array
// of register values plus an instruction count. A second instance with CNTW=2
// receives the same stimulus and checks counter wrap-around.
// -----------------------------------------------------------------------------
module tb_regfile_seq_ctrl;

    localparam int REGAW = 4;
    localparam int REGDW = 16;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid = 1'b0;
    logic [REGAW-1:0] req_rs1 = '0, req_rs2 = '0, req_rd = '0;
    logic             req_wb = 1'b0;
    logic             op_ready = 1'b0;
    logic             wb_valid = 1'b0;
    logic [REGDW-1:0] wb_data = '0;
    logic [REGDW-1:0] rs1_data, rs2_data;

    logic             req_ready, reg_wen, op_valid, wb_ready, busy;
    logic [REGAW-1:0] rs1_addr, rs2_addr, rd_addr;
    logic [REGDW-1:0] rd_data, op1, op2;
    logic [CNTW-1:0]  ret_cnt;

    logic             c2_req_ready, c2_reg_wen, c2_op_valid, c2_wb_ready, c2_busy;
    logic [REGAW-1:0] c2_rs1_addr, c2_rs2_addr, c2_rd_addr;
    logic [REGDW-1:0] c2_rd_data, c2_op1, c2_op2;
    logic [1:0]       c2_ret_cnt;

    always #5 clk = ~clk;

    regfile_seq_ctrl #(.REGAW(REGAW), .REGDW(REGDW), .CNTW(CNTW)) u_dut (
        .Clk_i(clk), .Rst_n_i(rst_n),
        .ReqValid_i(req_valid), .ReqReady_o(req_ready),
        .ReqRs1_i(req_rs1), .ReqRs2_i(req_rs2), .ReqRd_i(req_rd), .ReqWb_i(req_wb),
        .Rs1Addr_o(rs1_addr), .Rs2Addr_o(rs2_addr),
        .Rs1Data_i(rs1_data), .Rs2Data_i(rs2_data),
        .RegWEn_o(reg_wen), .RdAddr_o(rd_addr), .RdData_o(rd_data),
        .OpValid_o(op_valid), .OpReady_i(op_ready), .Op1_o(op1), .Op2_o(op2),
        .WbValid_i(wb_valid), .WbReady_o(wb_ready), .WbData_i(wb_data),
        .RetCnt_o(ret_cnt), .Busy_o(busy)
    );

    regfile_seq_ctrl #(.REGAW(REGAW), .REGDW(REGDW), .CNTW(2)) u_dut_c2 (
        .Clk_i(clk), .Rst_n_i(rst_n),
        .ReqValid_i(req_valid), .ReqReady_o(c2_req_ready),
        .ReqRs1_i(req_rs1), .ReqRs2_i(req_rs2), .ReqRd_i(req_rd), .ReqWb_i(req_wb),
        .Rs1Addr_o(c2_rs1_addr), .Rs2Addr_o(c2_rs2_addr),
        .Rs1Data_i(rs1_data), .Rs2Data_i(rs2_data),
        .RegWEn_o(c2_reg_wen), .RdAddr_o(c2_rd_addr), .RdData_o(c2_rd_data),
        .OpValid_o(c2_op_valid), .OpReady_i(op_ready), .Op1_o(c2_op1), .Op2_o(c2_op2),
        .WbValid_i(wb_valid), .WbReady_o(c2_wb_ready), .WbData_i(wb_data),
        .RetCnt_o(c2_ret_cnt), .Busy_o(c2_busy)
    );

    // Reference state: architectural register values and retired count.
    logic [REGDW-1:0] ref_rf [16];
    int unsigned      ref_cnt;

    // Register file model: registered read, written only by the DUT. It is
    // loaded from the reference contents on the first clock edge.
    logic [REGDW-1:0] env_rf [16];
    logic             env_loaded = 1'b0;
    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < 16; i++) env_rf[i] <= ref_rf[i];
            env_loaded <= 1'b1;
        end else if (reg_wen) begin
            env_rf[rd_addr] <= rd_data;
        end
        rs1_data <= env_rf[rs1_addr];
        rs2_data <= env_rf[rs2_addr];
    end

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    logic [REGAW-1:0] cur_rs1, cur_rs2, cur_rd;
    logic             cur_wb;
    logic [REGDW-1:0] cur_op1, cur_op2;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [REGDW-1:0] exp_op(input logic [REGAW-1:0] a);
`ifdef REGFILE_R0_ZERO_EN
        if (a == '0) return '0;
`endif
        return ref_rf[a];
    endfunction

    task automatic check_cnt(input string tag);
        check({tag, "_cnt"}, ret_cnt, ref_cnt % (1 << CNTW));
        check({tag, "_cnt2"}, c2_ret_cnt, ref_cnt % 4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; op_ready = 1'b0; wb_valid = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_wb_ready", wb_ready, 0);
        check("rst_reg_wen", reg_wen, 0);
        check("rst_ops", {op1, op2}, 0);
        check("rst_addrs", {rs1_addr, rs2_addr, rd_addr}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_cnt", ret_cnt, 0);
        step();
        step();
        rst_n = 1'b1;
        ref_cnt = 0;
        #1;
        check("rel_req_ready", req_ready, 1);
        check("rel_cnt", ret_cnt, 0);
    endtask

    // Issue a request and run it until operands are presented (OPND).
    task automatic start_instr(input logic [REGAW-1:0] rs1, input logic [REGAW-1:0] rs2,
                               input logic [REGAW-1:0] rd, input logic wb);
        check("idle_req_ready", req_ready, 1);
        cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd; cur_wb = wb;
        cur_op1 = exp_op(rs1); cur_op2 = exp_op(rs2);
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wb = wb;
        step();
        // Junk on the request bus must not reach the read addresses.
        req_valid = 1'b0;
        req_rs1 = REGAW'($urandom); req_rs2 = REGAW'($urandom);
        req_rd = REGAW'($urandom); req_wb = 1'($urandom);
        check("fetch_addrs", {rs1_addr, rs2_addr}, {rs1, rs2});
        check("fetch_state", {busy, req_ready, op_valid}, 3'b100);
        step();
        check("capt_op_valid", op_valid, 0);
        step();
        check("opnd_valid", op_valid, 1);
        check("opnd_ops", {op1, op2}, {cur_op1, cur_op2});
        check("opnd_rd_addr", rd_addr, rd);
    endtask

    // Hold operands for bp cycles, then complete the instruction.
    task automatic finish_instr(input logic [REGDW-1:0] wdata, input int bp, input int wbw);
        for (int i = 0; i < bp; i++) begin
            op_ready = 1'b0;
            req_valid = 1'($urandom);
            wb_valid = 1'($urandom);
            step();
            check("bp_hold", {op_valid, op1, op2, rs1_addr, wb_ready, reg_wen},
                  {1'b1, cur_op1, cur_op2, cur_rs1, 1'b0, 1'b0});
        end
        req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        if (!cur_wb) begin
            ref_cnt++;
            check("nowb_done", {op_valid, req_ready, reg_wen}, 3'b010);
        end else begin
            check("wbwait_entry", {wb_ready, op_valid}, 2'b10);
            for (int i = 0; i < wbw; i++) begin
                op_ready = 1'($urandom);
                step();
                check("wbwait_hold", {wb_ready, reg_wen}, 2'b10);
            end
            op_ready = 1'b0; wb_valid = 1'b1; wb_data = wdata;
            step();
            wb_valid = 1'b0; wb_data = REGDW'($urandom);
`ifdef REGFILE_R0_ZERO_EN
            if (cur_rd == '0) begin
                ref_cnt++;
                check("r0_no_write", {reg_wen, req_ready}, 2'b01);
            end else
`endif
            begin
                check("write_en", reg_wen, 1);
                check("write_port", {rd_addr, rd_data}, {cur_rd, wdata});
                ref_rf[cur_rd] = wdata;
                ref_cnt++;
                step();
                check("write_single", {reg_wen, req_ready}, 2'b01);
            end
        end
        check_cnt("retire");
    endtask

    initial begin
        int unsigned c0;
        for (int i = 0; i < 16; i++) ref_rf[i] = REGDW'($urandom);
        ref_rf[1] = 16'h0011;
        ref_rf[2] = 16'h0022;
        ref_cnt = 0;
        #1;
        do_reset();

        // Write then read with the result forwarded through the register file.
        start_instr(4'd1, 4'd2, 4'd3, 1'b1);
        check("wr_op1", op1, 16'h0011);
        check("wr_op2", op2, 16'h0022);
        finish_instr(16'h0033, 0, 1);
        // Five cycles of backpressure on the dependent read.
        start_instr(4'd3, 4'd2, 4'd5, 1'b0);
        check("raw_op1", op1, 16'h0033);
        finish_instr('0, 5, 0);

        // Reset during OPND drops the pending instruction.
        start_instr(4'd6, 4'd7, 4'd8, 1'b1);
        do_reset();

        // Back-to-back no-writeback throughput.
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            start_instr(REGAW'($urandom), REGAW'($urandom), REGAW'($urandom), 1'b0);
            finish_instr('0, 0, 0);
        end
        check("tput_cycles", cyc - c0, 12);
        check("tput_cnt", ret_cnt, 3);
        check("tput_no_wen", reg_wen, 0);

        // Two more retirements; the 2-bit counter wraps to 1.
        for (int i = 0; i < 2; i++) begin
            start_instr(REGAW'($urandom), REGAW'($urandom), REGAW'($urandom), 1'b0);
            finish_instr('0, 0, 0);
        end
        check("wrap_cnt2", c2_ret_cnt, 1);

        // Register 0 write followed by a read of register 0.
        start_instr(4'd5, 4'd6, 4'd0, 1'b1);
        finish_instr(16'hBEEF, 1, 0);
        start_instr(4'd0, 4'd1, 4'd4, 1'b0);
`ifdef REGFILE_R0_ZERO_EN
        check("r0_read", op1, 16'h0000);
`else
        check("r0_read", op1, 16'hBEEF);
`endif
        finish_instr('0, 0, 0);

        // Randomized instructions.
        for (int n = 0; n < 40; n++) begin
            start_instr(REGAW'($urandom), REGAW'($urandom), REGAW'($urandom), 1'($urandom));
            finish_instr(REGDW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
